// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use bubble insertion, redirect flush,
// PC / IF-ID write enables and saturating stall/flush event counters.
module id_ex_ctrl_stage #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_2_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  hold,
  input  logic                  ex_redirect,
  output logic                  ex_valid,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_2_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic                  r_valid;
  logic [9:0]            r_ctrl;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic                  w_lu;
  logic                  w_bubble;
  logic [9:0]            w_id_ctrl;

  assign w_id_ctrl = {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
                      id_mem_write, id_alu_src, id_reg_write, id_jump};

  // rs2 is compared even when the instruction has no rs2 operand; a spurious stall is harmless.
  assign w_lu = r_valid & ex_mem_read & (r_rd != '0) & id_valid &
                ((r_rd == id_rs1) | (r_rd == id_rs2));

  assign w_bubble = ex_redirect | w_lu;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
    end else if (w_lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hold) begin
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_rd    <= '0;
      end else begin
        r_valid <= id_valid;
        r_ctrl  <= id_valid ? w_id_ctrl : '0;
        r_rd    <= id_rd;
      end
      if (ex_redirect) begin
        if (r_flush_cnt != CntMax) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (w_lu) begin
        if (r_stall_cnt != CntMax) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign ex_valid     = r_valid;
  assign ex_alu_op    = r_ctrl[9:8];
  assign ex_reg_dst   = r_ctrl[7];
  assign ex_branch    = r_ctrl[6];
  assign ex_mem_read  = r_ctrl[5];
  assign ex_mem_2_reg = r_ctrl[4];
  assign ex_mem_write = r_ctrl[3];
  assign ex_alu_src   = r_ctrl[2];
  assign ex_reg_write = r_ctrl[1];
  assign ex_jump      = r_ctrl[0];
  assign ex_rd        = r_rd;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule
